// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the main control FSM and the iterative multiply/divide unit.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic             DivByZero;

    modport master (
        output Start, Op, SrcA, SrcB,
        input  Busy, Done, ResultLo, ResultHi, DivByZero
    );

    modport slave (
        input  Start, Op, SrcA, SrcB,
        output Busy, Done, ResultLo, ResultHi, DivByZero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative UMULL/SMULL/UDIV/SDIV unit: one result bit per cycle on operand magnitudes,
// followed by a single sign-fix cycle and a one-cycle Done pulse.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   res_lo_q;
    logic [WIDTH-1:0]   res_hi_q;

    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   fix_lo_d;
    logic [WIDTH-1:0]   fix_hi_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign a_neg    = bus.Op[0] & bus.SrcA[WIDTH-1];
    assign b_neg    = bus.Op[0] & bus.SrcB[WIDTH-1];
    assign a_mag    = magnitude(bus.SrcA, a_neg);
    assign b_mag    = magnitude(bus.SrcB, b_neg);
    assign div_zero = bus.Op[1] && (bus.SrcB == '0);

    // One iteration step; the pair {acc_q, lo_q} holds {acc, multiplier} or {rem, quotient}.
    always_comb begin
        mul_add  = lo_q[0] ? opnd_q : '0;
        mul_sum  = {1'b0, acc_q} + {1'b0, mul_add};
        div_sh   = {acc_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        acc_d    = mul_sum[WIDTH:1];
        lo_d     = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_d = div_diff[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_sh[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fix = negate_wide({acc_q, lo_q}, neg_lo_q);
        fix_lo_d = prod_fix[WIDTH-1:0];
        fix_hi_d = prod_fix[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fix_lo_d = magnitude(lo_q, neg_lo_q);
            fix_hi_d = magnitude(acc_q, neg_hi_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (bus.Start) begin
                        if (div_zero) begin
                            // Divide by zero bypasses the iteration entirely.
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            res_lo_q <= '1;
                            res_hi_q <= bus.SrcA;
                            dbz_q    <= 1'b1;
                        end else begin
                            state_q  <= S_RUN;
                            busy_q   <= 1'b1;
                            cnt_q    <= CW'(WIDTH - 1);
                            is_div_q <= bus.Op[1];
                            neg_lo_q <= a_neg ^ b_neg;
                            neg_hi_q <= a_neg;
                            acc_q    <= '0;
                            opnd_q   <= bus.Op[1] ? b_mag : a_mag;
                            lo_q     <= bus.Op[1] ? a_mag : b_mag;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q  <= S_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    res_lo_q <= fix_lo_d;
                    res_hi_q <= fix_hi_d;
                    dbz_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.ResultLo  = res_lo_q;
    assign bus.ResultHi  = res_hi_q;
    assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a plain-arithmetic reference.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: full-width integer arithmetic, truncating signed division.
    task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] lo, output logic [31:0] hi, output logic dbz,
                             output int lat);
        longint sa;
        longint sb;
        longint r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        lat = W + 2;
        lo  = '0;
        hi  = '0;
        case (op)
            2'd0: begin
                p  = {32'd0, a} * {32'd0, b};
                lo = p[31:0];
                hi = p[63:32];
            end
            2'd1: begin
                p  = 64'(sa * sb);
                lo = p[31:0];
                hi = p[63:32];
            end
            default: begin
                if (b == 32'd0) begin
                    lo  = 32'hFFFF_FFFF;
                    hi  = a;
                    dbz = 1'b1;
                    lat = 1;
                end else if (op == 2'd2) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    r  = sa / sb;
                    lo = r[31:0];
                    r  = sa % sb;
                    hi = r[31:0];
                end
            end
        endcase
    endtask

    // Called just after the accept edge; returns the cycle index (1 = first cycle after accept)
    // at which Done is seen. Optionally injects stray Start pulses at cycles 5 and 20.
    task automatic wait_done(input bit stray, output int cyc, output int busy_bad);
        cyc      = 1;
        busy_bad = 0;
        while (cyc <= 200 && !bus.Done) begin
            if (!bus.Busy) busy_bad++;
            if (stray && (cyc == 5 || cyc == 20)) begin
                bus.Start = 1'b1;
                bus.Op    = 2'd2;
                bus.SrcA  = $urandom;
                bus.SrcB  = 32'd0;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // mode 0: single op, mode 1: stray Start pulses while busy, mode 2: second op chained in DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int mode, input logic [1:0] op2,
                          input logic [31:0] a2, input logic [31:0] b2);
        logic [31:0] elo, ehi, elo2, ehi2;
        logic        edbz, edbz2;
        int          lat, lat2, cyc, cyc2, bb;
        ref_model(op, a, b, elo, ehi, edbz, lat);
        ref_model(op2, a2, b2, elo2, ehi2, edbz2, lat2);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        wait_done(mode == 1, cyc, bb);
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_busy_run"}, 64'(bb), 64'd0);
        chk({tag, "_busy_at_done"}, {63'd0, bus.Busy}, 64'd0);
        chk({tag, "_lo"}, {32'd0, bus.ResultLo}, {32'd0, elo});
        chk({tag, "_hi"}, {32'd0, bus.ResultHi}, {32'd0, ehi});
        chk({tag, "_dbz"}, {63'd0, bus.DivByZero}, {63'd0, edbz});
        if (mode == 2) begin
            bus.Start = 1'b1;
            bus.Op    = op2;
            bus.SrcA  = a2;
            bus.SrcB  = b2;
            @(posedge clk);
            #1;
            bus.Start = 1'b0;
            wait_done(1'b0, cyc2, bb);
            chk({tag, "_lat2"}, 64'(cyc + cyc2), 64'(lat + lat2));
            chk({tag, "_lo2"}, {32'd0, bus.ResultLo}, {32'd0, elo2});
            chk({tag, "_hi2"}, {32'd0, bus.ResultHi}, {32'd0, ehi2});
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {63'd0, bus.Done}, 64'd0);
    endtask

    initial begin
        int          hits;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 2'd0;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
        chk("rst_done", {63'd0, bus.Done}, 64'd0);
        chk("rst_lo", {32'd0, bus.ResultLo}, 64'd0);
        chk("rst_hi", {32'd0, bus.ResultHi}, 64'd0);
        chk("rst_dbz", {63'd0, bus.DivByZero}, 64'd0);
        reset = 1'b1;

        run_op("umull_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'd0, 0, 0);
        run_op("smull_m3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 0, 2'd0, 0, 0);
        run_op("umull_m3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 0, 2'd0, 0, 0);
        run_op("udiv_100_7", 2'd2, 32'd100, 32'd7, 0, 2'd0, 0, 0);
        run_op("sdiv_m100_7", 2'd3, 32'hFFFF_FF9C, 32'd7, 0, 2'd0, 0, 0);
        run_op("sdiv_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'd0, 0, 0);
        run_op("udiv_by0", 2'd2, 32'd5, 32'd0, 0, 2'd0, 0, 0);
        run_op("umull_3x4", 2'd0, 32'd3, 32'd4, 0, 2'd0, 0, 0);
        run_op("stray_start", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 2'd0, 0, 0);
        run_op("chain", 2'd1, 32'h8000_0000, 32'h8000_0000, 2, 2'd3, 32'hFFFF_FFF9, 32'd2);

        // Reset in the middle of a divide aborts it without a Done.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = 2'd2;
        bus.SrcA  = 32'd1000;
        bus.SrcB  = 32'd7;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
        chk("abort_lo", {32'd0, bus.ResultLo}, 64'd0);
        chk("abort_hi", {32'd0, bus.ResultHi}, 64'd0);
        hits = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.Done) hits++;
        end
        chk("abort_no_done", 64'(hits), 64'd0);
        run_op("udiv_9_3", 2'd2, 32'd9, 32'd3, 0, 2'd0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", rop, ra, rb, 0, 2'd0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
